// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for an N-digit common-anode
// 7-segment display that shares one BCD-to-7seg decoder across all digits.
// Digits are double-buffered: host loads land in a shadow register and are
// committed to the displayed word only at a frame boundary, so a frame never
// shows a mix of old and new digits. Each digit is preceded by a blanking gap
// so the previous digit's segments do not ghost onto the next anode.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zero digits).
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DWELL      = 1000,
  parameter int BLANK_CYC  = 16,
  localparam int IDXW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int MAXC      = (DWELL > BLANK_CYC) ? DWELL : BLANK_CYC,
  localparam int CNTW      = (MAXC > 1) ? $clog2(MAXC) : 1,
  localparam int DW        = 4 * NUM_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DW-1:0]         digits_in,
  output logic                  pending,
  output logic                  frame_tick,
  output logic [3:0]            bcd_out,
  output logic [NUM_DIGITS-1:0] an,
  output logic [IDXW-1:0]       digit_idx
);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t                state, stateNext;
  logic [CNTW-1:0]       cnt, cntNext;
  logic [IDXW-1:0]       idxNext;
  logic                  boundary;
  logic [DW-1:0]         active, activeNext;
  logic [DW-1:0]         shadow, shadowNext;
  logic                  pendingNext;
  logic [NUM_DIGITS-1:0] anNext;
  logic [3:0]            bcdNext;
  logic [3:0]            selDigit;
  logic                  hideDigit;

`ifdef LEADING_ZERO_BLANK_EN
  // True when digit idx and every more significant digit of act are zero.
  function automatic logic upperZero(input logic [DW-1:0] act, input logic [IDXW-1:0] idx);
    logic z;
    z = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((IDXW'(i) >= idx) && (act[4*i +: 4] != 4'h0)) z = 1'b0;
    end
    return z;
  endfunction
`endif

  // Scan sequencing: counter runs to the terminal value of the current phase,
  // then flips phase; leaving SHOW of the last digit marks the frame boundary.
  always_comb begin
    stateNext = state;
    cntNext   = cnt + CNTW'(1);
    idxNext   = digit_idx;
    boundary  = 1'b0;
    case (state)
      BLANK: begin
        if (cnt == CNTW'(BLANK_CYC - 1)) begin
          stateNext = SHOW;
          cntNext   = '0;
        end
      end
      SHOW: begin
        if (cnt == CNTW'(DWELL - 1)) begin
          stateNext = BLANK;
          cntNext   = '0;
          if (digit_idx == IDXW'(NUM_DIGITS - 1)) begin
            idxNext  = '0;
            boundary = 1'b1;
          end else begin
            idxNext = digit_idx + IDXW'(1);
          end
        end
      end
      default: begin
        stateNext = BLANK;
        cntNext   = '0;
      end
    endcase
  end

  // Double buffer: the boundary commits the old shadow first, so a load on the
  // same edge stays pending for the following frame.
  always_comb begin
    activeNext  = active;
    shadowNext  = shadow;
    pendingNext = pending;
    if (boundary && pending) begin
      activeNext  = shadow;
      pendingNext = 1'b0;
    end
    if (load) begin
      shadowNext  = digits_in;
      pendingNext = 1'b1;
    end
  end

  // Output decode from the next-state values so an/bcd_out register on the
  // same edge as the phase change, with no extra cycle of latency.
  always_comb begin
    selDigit  = activeNext[{idxNext, 2'b00} +: 4];
    hideDigit = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    hideDigit = (idxNext != '0) && upperZero(activeNext, idxNext);
`endif
    anNext  = '1;
    bcdNext = 4'hF;
    if (stateNext == SHOW && !hideDigit) begin
      bcdNext = selDigit;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idxNext == IDXW'(i)) anNext[i] = 1'b0;
      end
    end
  end

  // State, buffers and registered outputs; reset aborts any scan in progress
  // and takes priority over a coincident load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= BLANK;
      cnt        <= '0;
      digit_idx  <= '0;
      active     <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      frame_tick <= 1'b0;
      an         <= '1;
      bcd_out    <= 4'hF;
    end else begin
      state      <= stateNext;
      cnt        <= cntNext;
      digit_idx  <= idxNext;
      active     <= activeNext;
      shadow     <= shadowNext;
      pending    <= pendingNext;
      frame_tick <= boundary;
      an         <= anNext;
      bcd_out    <= bcdNext;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench for seg_scan_ctrl (4 digits, DWELL=4,
// BLANK_CYC=2, 24-cycle frame). Expected outputs are derived from the cycle
// position since reset and pushed per cycle; the DUT output is popped and
// compared one time unit after each rising edge.
module tb_seg_scan_ctrl;

  localparam int ND    = 4;
  localparam int DWL   = 4;
  localparam int BLK   = 2;
  localparam int PER   = DWL + BLK;
  localparam int FRAME = ND * PER;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits_in = '0;
  logic        pending;
  logic        frame_tick;
  logic [3:0]  bcd_out;
  logic [3:0]  an;
  logic [1:0]  digit_idx;

  int passCount = 0;
  int checkCount = 0;

  // Reference state: cycle position since reset plus the buffered words.
  int          pos = 0;
  logic [15:0] mShadow = '0;
  logic [15:0] mActive = '0;
  logic        mPending = 1'b0;
  logic [12:0] expQ[$];

  seg_scan_ctrl #(.NUM_DIGITS(ND), .DWELL(DWL), .BLANK_CYC(BLK)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in),
    .pending(pending), .frame_tick(frame_tick), .bcd_out(bcd_out),
    .an(an), .digit_idx(digit_idx)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Compare one observed value against its expectation and tally it.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Expected {frame_tick, pending, digit_idx, an, bcd_out} at position p.
  function automatic logic [12:0] expectAt(input int p);
    int          phase;
    int          dig;
    logic [3:0]  eAn;
    logic [3:0]  eBcd;
    logic [15:0] upper;
    logic        ft;
    phase = p % PER;
    dig   = (p / PER) % ND;
    eAn   = 4'b1111;
    eBcd  = 4'hF;
    if (phase >= BLK) begin
      eAn       = 4'b1111;
      eAn[dig]  = 1'b0;
      eBcd      = mActive[4*dig +: 4];
`ifdef LEADING_ZERO_BLANK_EN
      upper = mActive >> (4 * dig);
      if (dig > 0 && upper == 16'h0000) begin
        eAn  = 4'b1111;
        eBcd = 4'hF;
      end
`endif
    end
    ft = (p > 0) && (p % FRAME == 0);
    return {ft, mPending, 2'(dig), eAn, eBcd};
  endfunction

  // Drive one cycle of inputs, advance the reference, push the expectation,
  // then after the edge pop and compare against the DUT.
  task automatic applyStimulus(input logic rst, input logic ld, input logic [15:0] din);
    logic [12:0] e;
    @(negedge clk);
    rst_n     = ~rst;
    load      = ld;
    digits_in = din;
    if (rst) begin
      pos      = 0;
      mShadow  = '0;
      mActive  = '0;
      mPending = 1'b0;
    end else begin
      pos++;
      if (pos % FRAME == 0 && mPending) begin
        mActive  = mShadow;
        mPending = 1'b0;
      end
      if (ld) begin
        mShadow  = din;
        mPending = 1'b1;
      end
    end
    expQ.push_back(expectAt(pos));
    @(posedge clk);
    #1;
    e = expQ.pop_front();
    checkOutput($sformatf("pos%0d", pos), 32'({frame_tick, pending, digit_idx, an, bcd_out}), 32'(e));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 16'h0000);
  endtask

  // Idle until the next applied cycle lands on frame position m.
  task automatic idleUntil(input int m);
    for (int i = 0; i < 2 * FRAME && ((pos + 1) % FRAME) != m; i++) idle(1);
  endtask

  initial begin
    // Reset held three cycles, a load during reset must be ignored.
    applyStimulus(1'b1, 1'b0, 16'h0000);
    applyStimulus(1'b1, 1'b1, 16'hBEEF);
    applyStimulus(1'b1, 1'b0, 16'h0000);
    checkOutput("rst_an", 32'(an), 32'h0000000F);
    checkOutput("rst_bcd", 32'(bcd_out), 32'h0000000F);
    checkOutput("rst_pending", 32'(pending), 32'h0);
    checkOutput("rst_idx", 32'(digit_idx), 32'h0);

    // Basic scan of 1234 for two frames.
    applyStimulus(1'b0, 1'b1, 16'h1234);
    idle(2 * FRAME + 2);

    // Mid-frame load: current frame keeps 1234, next shows 5678.
    idleUntil(9);
    applyStimulus(1'b0, 1'b1, 16'h5678);
    checkOutput("mid_pending", 32'(pending), 32'h1);
    idle(FRAME + 4);

    // Coincident load on the boundary edge.
    idleUntil(5);
    applyStimulus(1'b0, 1'b1, 16'h0042);
    idleUntil(0);
    applyStimulus(1'b0, 1'b1, 16'h9999);
    checkOutput("coinc_pending", 32'(pending), 32'h1);
    idle(2 * FRAME);

    // Non-BCD nibbles pass through.
    applyStimulus(1'b0, 1'b1, 16'hFEDC);
    idle(2 * FRAME);

    // Reset in the middle of digit 2's SHOW with a coincident load.
    idleUntil(15);
    applyStimulus(1'b1, 1'b1, 16'hAAAA);
    checkOutput("midrst_an", 32'(an), 32'h0000000F);
    checkOutput("midrst_idx", 32'(digit_idx), 32'h0);
    idle(FRAME + 2);

    // Leading-zero case: only digit 0 lit when the feature is built in.
    applyStimulus(1'b0, 1'b1, 16'h0007);
    idle(2 * FRAME + 3);

    if (expQ.size() != 0) checkOutput("queue_empty", 32'(expQ.size()), 32'h0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
